// File: rtl/audio_mix_pkg.sv
// Shared constants and helpers for the audio mixer output stage.
// Channel indices, volume limit and output saturation.
package audio_mix_pkg;

  localparam int SAMPLE_W_DEF = 32;

  localparam int CH_PULSE1   = 0;
  localparam int CH_PULSE2   = 1;
  localparam int CH_TRIANGLE = 2;
  localparam int CH_NOISE    = 3;

  localparam int VOL_MAX = 16;

  // Clamp a wide signed value to the range of a w-bit signed sample.
  function automatic logic signed [63:0] sat_to_sample(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/audio_mix_out_stage_fifo.sv
// First-word-fall-through sample FIFO.
// Head entry is visible on dout; dout reads 0 when empty.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock_pulse,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  // A pop frees the slot the push lands in, so full+pop still accepts.
  assign do_push = push & (~full | pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock_pulse) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock_pulse) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/audio_mix_out_stage.sv
// Mixes four synth channels at the codec rate, scales, saturates,
// buffers and drains to the codec via the write/allowed handshake.
module audio_mix_out_stage
  import audio_mix_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int SAMPLE_DIV = 1042,
  parameter int DEPTH      = 8
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] pulse1_sample,
  input  logic signed [SAMPLE_W-1:0] pulse2_sample,
  input  logic signed [SAMPLE_W-1:0] triangle_sample,
  input  logic signed [SAMPLE_W-1:0] noise_sample,
  input  logic [3:0]                 mix_enable,
  input  logic [4:0]                 master_volume,
  input  logic                       audio_out_allowed,
  output logic                       write_audio_out,
  output logic [SAMPLE_W-1:0]        left_channel_audio_out,
  output logic [SAMPLE_W-1:0]        right_channel_audio_out,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [15:0]                overflow_count
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SW2 = SAMPLE_W + 2;
  localparam int PW = SW2 + 6;

  logic [CW-1:0]          count;
  logic                   tick;
  logic                   v1;
  logic                   v2;
  logic signed [SW2-1:0]  sum;
  logic signed [SW2-1:0]  mix1_q;
  logic [4:0]             vol_c;
  logic signed [PW-1:0]   prod;
  logic signed [PW-1:0]   prod_sh;
  logic signed [63:0]     wide;
  logic [SAMPLE_W-1:0]    mix2_q;
  logic                   empty;
  logic                   full;
  logic                   pop;
  logic                   drop;
  logic [SAMPLE_W-1:0]    head;

  assign tick = (count == CW'(SAMPLE_DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) count <= '0;
    else       count <= tick ? '0 : count + 1'b1;
  end

  always_comb begin
    sum = '0;
    if (mix_enable[CH_PULSE1])
      sum = sum + {{2{pulse1_sample[SAMPLE_W-1]}}, pulse1_sample};
    if (mix_enable[CH_PULSE2])
      sum = sum + {{2{pulse2_sample[SAMPLE_W-1]}}, pulse2_sample};
    if (mix_enable[CH_TRIANGLE])
      sum = sum + {{2{triangle_sample[SAMPLE_W-1]}}, triangle_sample};
    if (mix_enable[CH_NOISE])
      sum = sum + {{2{noise_sample[SAMPLE_W-1]}}, noise_sample};
  end

  // Volume is latched with the mix so later changes miss in-flight samples.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      v1     <= 1'b0;
      mix1_q <= '0;
      vol_c  <= '0;
    end else begin
      v1 <= tick;
      if (tick) begin
        mix1_q <= sum;
        vol_c  <= (master_volume > 5'(VOL_MAX)) ? 5'(VOL_MAX)
                                                 : master_volume;
      end
    end
  end

  assign prod    = PW'(mix1_q) * $signed({1'b0, vol_c});
  assign prod_sh = prod >>> 4;
  assign wide    = {{(64-PW){prod_sh[PW-1]}}, prod_sh};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      v2     <= 1'b0;
      mix2_q <= '0;
    end else begin
      v2 <= v1;
      if (v1) mix2_q <= SAMPLE_W'(sat_to_sample(wide, SAMPLE_W));
    end
  end

  assign pop             = audio_out_allowed & ~empty;
  assign write_audio_out = pop;
  assign drop            = v2 & full & ~pop;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_pulse (CLOCK_50),
    .reset       (reset),
    .push        (v2),
    .din         (mix2_q),
    .pop         (pop),
    .dout        (head),
    .empty       (empty),
    .full        (full),
    .level       (fifo_level)
  );

  assign left_channel_audio_out  = head;
  assign right_channel_audio_out = head;

  always_ff @(posedge CLOCK_50) begin
    if (reset)
      overflow_count <= '0;
    else if (drop && overflow_count != 16'hFFFF)
      overflow_count <= overflow_count + 16'd1;
  end

endmodule

// File: tb/tb_audio_mix_out_stage.sv
// Directed bench for audio_mix_out_stage with SAMPLE_DIV=8, DEPTH=8.
module tb_audio_mix_out_stage;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] p1 = '0;
  logic signed [31:0] p2 = '0;
  logic signed [31:0] tr = '0;
  logic signed [31:0] nz = '0;
  logic [3:0]         mask = '0;
  logic [4:0]         vol = '0;
  logic               allowed = 1'b0;
  logic               wr;
  logic [31:0]        left;
  logic [31:0]        right;
  logic [3:0]         level;
  logic [15:0]        ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  audio_mix_out_stage #(
    .SAMPLE_W   (32),
    .SAMPLE_DIV (8),
    .DEPTH      (8)
  ) dut (
    .CLOCK_50                (clk),
    .reset                   (reset),
    .pulse1_sample           (p1),
    .pulse2_sample           (p2),
    .triangle_sample         (tr),
    .noise_sample            (nz),
    .mix_enable              (mask),
    .master_volume           (vol),
    .audio_out_allowed       (allowed),
    .write_audio_out         (wr),
    .left_channel_audio_out  (left),
    .right_channel_audio_out (right),
    .fifo_level              (level),
    .overflow_count          (ovf)
  );

  typedef struct {
    logic signed [31:0] p1;
    logic signed [31:0] p2;
    logic signed [31:0] tr;
    logic signed [31:0] nz;
    logic [3:0]         mask;
    logic [4:0]         vol;
    logic [31:0]        exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic wait_write();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wr) begin
        seen = 1'b1;
        break;
      end
    end
    chk("write_timeout", 64'(seen), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_ticks(input int n, input int start);
    p1 = start;
    for (int i = 0; i < n; i++) begin
      repeat (8) @(negedge clk);
      p1 = p1 + 1;
    end
  endtask

  initial begin
    int   n;
    logic wrote;

    vecs[0] = '{1000, 2000, -500, 7, 4'b0111, 5'd16, 32'd2500};
    vecs[1] = '{1001, 0, 0, 0, 4'b0001, 5'd8, 32'd500};
    vecs[2] = '{-1001, 0, 0, 0, 4'b0001, 5'd8, -32'sd501};
    vecs[3] = '{1001, 0, 0, 0, 4'b0001, 5'd31, 32'd1001};
    vecs[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                32'h7FFFFFFF, 4'b1111, 5'd16, 32'h7FFFFFFF};
    vecs[5] = '{32'h80000000, 32'h80000000, 32'h80000000,
                32'h80000000, 4'b1111, 5'd16, 32'h80000000};
    vecs[6] = '{1000, 2000, -500, 7, 4'b1000, 5'd16, 32'd7};
    vecs[7] = '{0, 2000, 0, 0, 4'b0010, 5'd1, 32'd125};
    vecs[8] = '{1000, 2000, -500, 7, 4'b0111, 5'd0, 32'd0};

    // Reset state and first-tick latency
    repeat (3) @(negedge clk);
    chk("rst_write", 64'(wr), 64'd0);
    chk("rst_left", 64'(left), 64'd0);
    chk("rst_right", 64'(right), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    reset = 1'b0;
    repeat (9) @(negedge clk);
    chk("level_before_n3", 64'(level), 64'd0);
    @(negedge clk);
    chk("level_at_n3", 64'(level), 64'd1);

    // Mixing table
    do_reset();
    allowed = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wait_write();
      p1 = vecs[i].p1;
      p2 = vecs[i].p2;
      tr = vecs[i].tr;
      nz = vecs[i].nz;
      mask = vecs[i].mask;
      vol = vecs[i].vol;
      wait_write();
      chk($sformatf("vec%0d_left", i), 64'(left), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_right", i), 64'(right), 64'(vecs[i].exp));
    end

    // One write per tick
    wait_write();
    n = 0;
    repeat (16) begin
      @(negedge clk);
      if (wr) n++;
    end
    chk("writes_per_2_ticks", 64'(n), 64'd2);

    // Overflow then in-order drain
    p2 = 0; tr = 0; nz = 0;
    mask = 4'b0001;
    vol = 5'd16;
    allowed = 1'b0;
    do_reset();
    run_ticks(10, 1);
    repeat (3) @(negedge clk);
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_count", 64'(ovf), 64'd2);
    allowed = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk($sformatf("drain%0d_write", i), 64'(wr), 64'd1);
      chk($sformatf("drain%0d_val", i), 64'(left), 64'(i));
      @(negedge clk);
    end
    allowed = 1'b0;

    // Push and pop in the same cycle while full
    do_reset();
    run_ticks(8, 1);
    repeat (9) @(negedge clk);
    chk("full_level", 64'(level), 64'd8);
    allowed = 1'b1;
    #1;
    chk("full_pop_write", 64'(wr), 64'd1);
    chk("full_pop_val", 64'(left), 64'd1);
    @(negedge clk);
    allowed = 1'b0;
    #1;
    chk("full_pp_level", 64'(level), 64'd8);
    chk("full_pp_ovf", 64'(ovf), 64'd0);
    chk("full_pp_head", 64'(left), 64'd2);

    // Reset while draining with a sample in stage 2
    do_reset();
    run_ticks(5, 1);
    repeat (8) @(negedge clk);
    chk("mid_level5", 64'(level), 64'd5);
    reset = 1'b1;
    allowed = 1'b1;
    @(negedge clk);
    chk("mid_level", 64'(level), 64'd0);
    chk("mid_write", 64'(wr), 64'd0);
    chk("mid_left", 64'(left), 64'd0);
    chk("mid_ovf", 64'(ovf), 64'd0);
    reset = 1'b0;
    wrote = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wr) wrote = 1'b1;
    end
    chk("mid_no_stale_write", 64'(wrote), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
